// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: FETCH/DECODE/EXEC/MEM/WB sequencer for the multi-cycle RV32I core,
// with memory wait-state handling, timeout watchdog and retired-instruction counter.
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic             branch,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic [2:0]       state,
  output logic             halted,
  output logic             bus_error,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_retired
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd7
  } state_e;
  localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);
  state_e           state_q, state_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [CNT_W-1:0] instr_retired_q, instr_retired_d;
  logic             bus_error_q, bus_error_d;
  logic             illegal_q, illegal_d;
  logic             retire, waiting, timeout;
  logic             is_r, is_i, is_lw, is_sw, is_beq, legal;
  assign is_r    = opcode == 7'b0110011;
  assign is_i    = opcode == 7'b0010011;
  assign is_lw   = opcode == 7'b0000011;
  assign is_sw   = opcode == 7'b0100011;
  assign is_beq  = opcode == 7'b1100011;
  assign legal   = is_r | is_i | is_lw | is_sw | is_beq;
  // Last permitted wait cycle of an access; a miss here abandons it.
  assign timeout = (MEM_TIMEOUT != 0) && (wait_q == WAIT_LAST);
  always_comb begin
    state_d     = state_q;
    bus_error_d = bus_error_q;
    illegal_d   = illegal_q;
    retire      = 1'b0;
    waiting     = 1'b0;
    {mem_req, mem_we, i_or_d, ir_write, pc_write, branch, alu_src_a} = '0;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    halted      = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        waiting   = !mem_ready;
        state_d   = mem_ready ? DECODE : timeout ? TRAP : FETCH;
        bus_error_d = bus_error_q | (!mem_ready & timeout);
      end
      DECODE: begin
        state_d   = legal ? EXEC : TRAP;
        illegal_d = illegal_q | !legal;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = (is_r | is_beq) ? 2'b00 : 2'b10;
        alu_op    = (is_r | is_i) ? 2'b10 : is_beq ? 2'b01 : 2'b00;
        branch    = is_beq;
        retire    = is_beq;
        state_d   = (is_r | is_i) ? WB : (is_lw | is_sw) ? MEM : is_beq ? FETCH : TRAP;
        illegal_d = illegal_q | !legal;
      end
      MEM: begin
        mem_req   = 1'b1;
        i_or_d    = 1'b1;
        mem_we    = is_sw;
        waiting   = !mem_ready;
        retire    = mem_ready & is_sw;
        state_d   = mem_ready ? (is_sw ? FETCH : WB) : timeout ? TRAP : MEM;
        bus_error_d = bus_error_q | (!mem_ready & timeout);
      end
      WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_lw;
        retire     = 1'b1;
        state_d    = FETCH;
      end
      TRAP: halted = 1'b1;
      default: begin
        state_d   = TRAP;
        illegal_d = 1'b1;
      end
    endcase
    wait_d          = (state_d != state_q) ? '0 : waiting ? wait_q + WW'(1) : wait_q;
    instr_retired_d = instr_retired_q + CNT_W'(retire);
    // Reset must silence the memory port before the clock ever ticks.
    if (!rst_n) begin
      {mem_req, mem_we, i_or_d, ir_write, pc_write, branch, alu_src_a} = '0;
      {alu_src_b, alu_op, reg_write, mem_to_reg, halted} = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= FETCH;
      wait_q          <= '0;
      instr_retired_q <= '0;
      bus_error_q     <= 1'b0;
      illegal_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      wait_q          <= wait_d;
      instr_retired_q <= instr_retired_d;
      bus_error_q     <= bus_error_d;
      illegal_q       <= illegal_d;
    end
  end
  assign state         = state_q;
  assign bus_error     = bus_error_q;
  assign illegal       = illegal_q;
  assign instr_retired = instr_retired_q;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: randomized instruction streams checked cycle by cycle against
// an instruction-level schedule, plus trap, timeout and reset scenarios.
module tb_multicycle_control_fsm;
  localparam int TO = 4;
  localparam int CW = 4;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011,
                         OP_SW = 7'b0100011, OP_BEQ = 7'b1100011;
  typedef struct packed {
    logic       mem_req, mem_we, i_or_d, ir_write, pc_write, branch, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       reg_write, mem_to_reg, halted;
  } ctl_t;
  typedef struct packed {
    logic [6:0] op;
    logic       rdy;
    logic [2:0] st;
    ctl_t       ctl;
  } cyc_t;
  logic clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0;
  logic [6:0] opcode = '0;
  logic mem_req, mem_we, i_or_d, ir_write, pc_write, branch, alu_src_a, reg_write, mem_to_reg;
  logic [1:0] alu_src_b, alu_op;
  logic [2:0] state;
  logic halted, bus_error, illegal;
  logic [CW-1:0] instr_retired;
  ctl_t obs;
  cyc_t q[$];
  int n_cmp = 0, n_err = 0;
  logic [CW-1:0] exp_cnt = '0;
  logic [6:0] ops [5] = '{OP_R, OP_I, OP_LW, OP_SW, OP_BEQ};

  multicycle_control_fsm #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .branch(branch), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .state(state),
    .halted(halted), .bus_error(bus_error), .illegal(illegal), .instr_retired(instr_retired)
  );
  assign obs = {mem_req, mem_we, i_or_d, ir_write, pc_write, branch, alu_src_a,
                alu_src_b, alu_op, reg_write, mem_to_reg, halted};
  always #5 clk = ~clk;

  // Expands one instruction into its expected per-cycle schedule.
  function automatic void plan(input logic [6:0] op, input int fw, input int mw);
    cyc_t c;
    bit r = op == OP_R, i = op == OP_I, ld = op == OP_LW, sw = op == OP_SW, b = op == OP_BEQ;
    for (int k = 0; k <= fw; k++) begin
      c = '0; c.op = 7'($urandom); c.rdy = (k == fw); c.st = 3'd0;
      c.ctl.mem_req = 1'b1; c.ctl.alu_src_b = 2'b01;
      c.ctl.ir_write = c.rdy; c.ctl.pc_write = c.rdy;
      q.push_back(c);
    end
    c = '0; c.op = op; c.rdy = 1'($urandom); c.st = 3'd1;
    q.push_back(c);
    c = '0; c.op = op; c.rdy = 1'($urandom); c.st = 3'd2;
    c.ctl.alu_src_a = 1'b1;
    c.ctl.alu_src_b = (i | ld | sw) ? 2'b10 : 2'b00;
    c.ctl.alu_op = (r | i) ? 2'b10 : b ? 2'b01 : 2'b00;
    c.ctl.branch = b;
    q.push_back(c);
    if (ld | sw)
      for (int k = 0; k <= mw; k++) begin
        c = '0; c.op = op; c.rdy = (k == mw); c.st = 3'd3;
        c.ctl.mem_req = 1'b1; c.ctl.i_or_d = 1'b1; c.ctl.mem_we = sw;
        q.push_back(c);
      end
    if (r | i | ld) begin
      c = '0; c.op = op; c.rdy = 1'($urandom); c.st = 3'd4;
      c.ctl.reg_write = 1'b1; c.ctl.mem_to_reg = ld;
      q.push_back(c);
    end
  endfunction

  task automatic cyc(input logic [6:0] op, input logic rdy);
    opcode = op; mem_ready = rdy;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; mem_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; exp_cnt = '0;
  endtask

  task automatic test_reset();
    mem_ready = 1'b1;
    #2;
    n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", state); end
    n_cmp++; if (obs !== ctl_t'('0)) begin n_err++; $display("FAIL reset_ctl got %h want 0", obs); end
    n_cmp++; if ({bus_error, illegal, instr_retired} !== '0) begin n_err++;
      $display("FAIL reset_status got be=%b il=%b cnt=%0d want 0", bus_error, illegal, instr_retired); end
    @(posedge clk); #1; rst_n = 1'b1; mem_ready = 1'b0; #1;
    n_cmp++; if (mem_req !== 1'b1 || state !== 3'd0) begin n_err++;
      $display("FAIL reset_release got req=%b st=%0d want req=1 st=0", mem_req, state); end
    do_reset();
  endtask

  task automatic test_instructions(input int n_rand);
    cyc_t c;
    logic [6:0] op;
    for (int n = 0; n < 4 + n_rand; n++) begin
      case (n)
        0: plan(OP_R, 0, 0);
        1: plan(OP_LW, 0, 3);
        2: plan(OP_SW, 0, 0);
        3: plan(OP_BEQ, 0, 0);
        default: begin
          op = ops[$urandom_range(0, 4)];
          plan(op, $urandom_range(0, TO - 1), $urandom_range(0, TO - 1));
        end
      endcase
      while (q.size() > 0) begin
        c = q.pop_front();
        opcode = c.op; mem_ready = c.rdy; #1;
        n_cmp++; if (state !== c.st) begin n_err++; $display("FAIL instr%0d_state got %0d want %0d", n, state, c.st); end
        n_cmp++; if (obs !== c.ctl) begin n_err++; $display("FAIL instr%0d_ctl st=%0d got %h want %h", n, c.st, obs, c.ctl); end
        n_cmp++; if (instr_retired !== exp_cnt) begin n_err++;
          $display("FAIL instr%0d_cnt got %0d want %0d", n, instr_retired, exp_cnt); end
        @(posedge clk); #1;
      end
      exp_cnt = exp_cnt + 1'b1;
    end
    #1;
    n_cmp++; if (instr_retired !== exp_cnt || state !== 3'd0 || bus_error !== 1'b0 || illegal !== 1'b0) begin n_err++;
      $display("FAIL stream_end got cnt=%0d st=%0d be=%b il=%b want cnt=%0d st=0", instr_retired, state, bus_error, illegal, exp_cnt); end
  endtask

  task automatic test_illegal();
    logic [6:0] bad;
    ctl_t h;
    h = '0; h.halted = 1'b1;
    bad = 7'b1111111;
    for (int t = 0; t < 2; t++) begin
      do_reset();
      cyc(OP_R, 1'b1);
      opcode = bad; mem_ready = 1'($urandom); #1;
      n_cmp++; if (state !== 3'd1) begin n_err++; $display("FAIL illegal_decode got %0d want 1", state); end
      @(posedge clk); #1;
      for (int k = 0; k < 20; k++) begin
        mem_ready = 1'($urandom); #1;
        n_cmp++; if (state !== 3'd7 || obs !== h) begin n_err++;
          $display("FAIL illegal_trap op=%b cyc%0d got st=%0d ctl=%h want st=7 ctl=%h", bad, k, state, obs, h); end
        n_cmp++; if (illegal !== 1'b1 || bus_error !== 1'b0 || instr_retired !== 0) begin n_err++;
          $display("FAIL illegal_flags got il=%b be=%b cnt=%0d want il=1 be=0 cnt=0", illegal, bus_error, instr_retired); end
        @(posedge clk); #1;
      end
      do bad = 7'($urandom); while (bad == OP_R || bad == OP_I || bad == OP_LW || bad == OP_SW || bad == OP_BEQ);
    end
    do_reset();
    n_cmp++; if (illegal !== 1'b0 || halted !== 1'b0) begin n_err++;
      $display("FAIL illegal_clear got il=%b halted=%b want 0", illegal, halted); end
  endtask

  task automatic test_timeout();
    for (int k = 0; k < TO; k++) begin
      opcode = 7'($urandom); mem_ready = 1'b0; #1;
      n_cmp++; if (mem_req !== 1'b1 || state !== 3'd0) begin n_err++;
        $display("FAIL fetch_to_req cyc%0d got req=%b st=%0d want req=1 st=0", k, mem_req, state); end
      @(posedge clk); #1;
    end
    n_cmp++; if (state !== 3'd7 || bus_error !== 1'b1 || halted !== 1'b1 || mem_req !== 1'b0 || illegal !== 1'b0) begin n_err++;
      $display("FAIL fetch_to_trap got st=%0d be=%b h=%b req=%b il=%b want st=7 be=1 h=1 req=0 il=0", state, bus_error, halted, mem_req, illegal); end
    do_reset();
    n_cmp++; if (bus_error !== 1'b0) begin n_err++; $display("FAIL bus_error_clear got %b want 0", bus_error); end
    for (int k = 0; k < TO; k++) cyc(7'($urandom), k == TO - 1);
    n_cmp++; if (state !== 3'd1 || bus_error !== 1'b0) begin n_err++;
      $display("FAIL fetch_late_ready got st=%0d be=%b want st=1 be=0", state, bus_error); end
    do_reset();
    cyc(OP_LW, 1'b1); cyc(OP_LW, 1'b0); cyc(OP_LW, 1'b0);
    for (int k = 0; k < TO; k++) begin
      mem_ready = 1'b0; #1;
      n_cmp++; if (mem_req !== 1'b1 || i_or_d !== 1'b1 || state !== 3'd3) begin n_err++;
        $display("FAIL mem_to_req cyc%0d got req=%b iod=%b st=%0d want 1 1 3", k, mem_req, i_or_d, state); end
      @(posedge clk); #1;
    end
    n_cmp++; if (state !== 3'd7 || bus_error !== 1'b1 || instr_retired !== 0) begin n_err++;
      $display("FAIL mem_to_trap got st=%0d be=%b cnt=%0d want st=7 be=1 cnt=0", state, bus_error, instr_retired); end
    do_reset();
  endtask

  task automatic test_reset_mid_mem();
    cyc(OP_BEQ, 1'b1); cyc(OP_BEQ, 1'b0); cyc(OP_BEQ, 1'b0);
    n_cmp++; if (instr_retired !== 1) begin n_err++; $display("FAIL beq_retire got %0d want 1", instr_retired); end
    cyc(OP_SW, 1'b1); cyc(OP_SW, 1'b0); cyc(OP_SW, 1'b0);
    mem_ready = 1'b0; #1;
    n_cmp++; if (state !== 3'd3 || mem_we !== 1'b1) begin n_err++;
      $display("FAIL sw_mem got st=%0d we=%b want st=3 we=1", state, mem_we); end
    #2; rst_n = 1'b0; #1;
    n_cmp++; if (obs !== ctl_t'('0) || state !== 3'd0 || instr_retired !== 0) begin n_err++;
      $display("FAIL async_reset got ctl=%h st=%0d cnt=%0d want 0", obs, state, instr_retired); end
    @(posedge clk); #1; rst_n = 1'b1; #1;
    n_cmp++; if (state !== 3'd0 || mem_req !== 1'b1 || instr_retired !== 0 || bus_error !== 1'b0) begin n_err++;
      $display("FAIL post_reset got st=%0d req=%b cnt=%0d be=%b want st=0 req=1 cnt=0 be=0", state, mem_req, instr_retired, bus_error); end
  endtask

  initial begin
    test_reset();
    test_instructions(20);
    test_illegal();
    test_timeout();
    test_reset_mid_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
